// File: rtl/serv_ctrl_wide.sv
// W-bit serial PC/control unit: holds the PC, streams PC+INC, PC/rs1+offset and
// trap vectors LSB-first, and raises an instruction-fetch request after each update.
module serv_ctrl_wide #(
    parameter logic [31:0] RESET_PC   = 32'd8,
    parameter int          W          = 1,
    parameter bit          COMPRESSED = 1'b0
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_pc_en,
    input  logic         i_jump,
    input  logic         i_jalr,
    input  logic         i_auipc,
    input  logic         i_lui,
    input  logic         i_trap,
    input  logic         i_iscomp,
    input  logic [W-1:0] i_offset,
    input  logic [W-1:0] i_rs1,
    input  logic [W-1:0] i_csr_pc,
    output logic [W-1:0] o_rd,
    output logic [W-1:0] o_bad_pc,
    output logic         o_misalign,
    output logic [31:0]  o_ibus_adr,
    output logic         o_ibus_cyc,
    input  logic         i_ibus_ack
);
    localparam int N  = 32 / W;
    localparam int CW = $clog2(N);
    localparam int LW = $clog2(W);
    localparam int W1 = W + 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic          inc_c_q, inc_c_d;
    logic          off_c_q, off_c_d;
    logic          mis_q, mis_d;
    logic          cyc_q, cyc_d;
    logic          pc_en_q;

    logic [4:0]    sh;
    logic [31:0]   inc_word, inc_sh, tgt_mask_sh, csr_mask_sh;
    logic [W-1:0]  pc_beat, inc_beat, inc_sum, a_beat, tgt_raw, tgt_beat, csr_beat, new_beat;
    logic          inc_co, off_co, step, wrap;
    logic          mis_sample, mis_bit;

    // Target bit 1 lives in beat 1 when the datapath is one bit wide.
    generate
        if (W == 1) begin : g_mis_w1
            assign mis_sample = (cnt_q == CW'(1));
            assign mis_bit    = tgt_raw[0];
        end else begin : g_mis_wn
            assign mis_sample = (cnt_q == '0);
            assign mis_bit    = tgt_raw[1];
        end
    endgenerate

    always_comb begin
        step     = i_pc_en | i_en;
        wrap     = step && (cnt_q == CW'(N - 1));
        sh       = 5'(cnt_q) << LW;
        pc_beat  = pc_q[W-1:0];

        inc_word = (COMPRESSED && i_iscomp) ? 32'd2 : 32'd4;
        inc_sh   = inc_word >> sh;
        inc_beat = inc_sh[W-1:0];
        {inc_co, inc_sum} = {1'b0, pc_beat} + {1'b0, inc_beat} + W1'(inc_c_q);

        a_beat   = i_jalr ? i_rs1 : pc_beat;
        {off_co, tgt_raw} = {1'b0, a_beat} + {1'b0, i_offset} + W1'(off_c_q);

        // Masks shifted down to the current beat clear only the absolute low bits.
        tgt_mask_sh = 32'hFFFF_FFFE >> sh;
        csr_mask_sh = 32'hFFFF_FFFC >> sh;
        tgt_beat    = tgt_raw & tgt_mask_sh[W-1:0];
        csr_beat    = i_csr_pc & csr_mask_sh[W-1:0];

        new_beat = i_trap ? csr_beat : (i_jump ? tgt_beat : inc_sum);
        o_rd     = i_lui ? i_offset : (i_auipc ? tgt_beat : inc_sum);
        o_bad_pc = tgt_beat;

        cnt_d   = step ? (wrap ? '0 : cnt_q + CW'(1)) : cnt_q;
        inc_c_d = wrap ? 1'b0 : (step ? inc_co : inc_c_q);
        off_c_d = (wrap || !step) ? 1'b0 : off_co;
        pc_d    = i_pc_en ? {new_beat, pc_q[31:W]} : pc_q;

        mis_d = mis_q;
        if (COMPRESSED)
            mis_d = 1'b0;
        else if (i_en && mis_sample)
            mis_d = mis_bit;

        cyc_d = cyc_q;
        if (cyc_q && i_ibus_ack)
            cyc_d = 1'b0;
        if (pc_en_q && !i_pc_en)
            cyc_d = 1'b1;
        if (i_pc_en && !pc_en_q && cyc_q)
            cyc_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            pc_q    <= RESET_PC;
            inc_c_q <= 1'b0;
            off_c_q <= 1'b0;
            mis_q   <= 1'b0;
            cyc_q   <= 1'b0;
            pc_en_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            inc_c_q <= inc_c_d;
            off_c_q <= off_c_d;
            mis_q   <= mis_d;
            cyc_q   <= cyc_d;
            pc_en_q <= i_pc_en;
        end
    end

    assign o_misalign = mis_q;
    assign o_ibus_adr = pc_q;
    assign o_ibus_cyc = cyc_q;
endmodule

// File: tb/tb_serv_ctrl_wide.sv
// Directed bench: five instances covering W=1/2/4/8 and both COMPRESSED settings,
// each driven one serial update at a time with hand-computed results.
module tb_serv_ctrl_wide;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        en[5], pc_en[5], jump[5], jalr[5], auipc[5], lui[5], trap[5], iscomp[5], ack[5];
    logic [7:0]  off[5], rs1[5], csr[5];
    logic [7:0]  rd_all[5], bad_all[5];
    logic        mis[5], cyc[5];
    logic [31:0] adr[5];

    logic [0:0] rd0, bad0;
    logic [3:0] rd1, bad1;
    logic [1:0] rd2, bad2, rd3, bad3;
    logic [7:0] rd4, bad4;

    assign rd_all[0] = {7'd0, rd0};  assign bad_all[0] = {7'd0, bad0};
    assign rd_all[1] = {4'd0, rd1};  assign bad_all[1] = {4'd0, bad1};
    assign rd_all[2] = {6'd0, rd2};  assign bad_all[2] = {6'd0, bad2};
    assign rd_all[3] = {6'd0, rd3};  assign bad_all[3] = {6'd0, bad3};
    assign rd_all[4] = rd4;          assign bad_all[4] = bad4;

    serv_ctrl_wide #(.W(1)) u_w1 (
        .clk(clk), .i_rst(rst), .i_en(en[0]), .i_pc_en(pc_en[0]), .i_jump(jump[0]),
        .i_jalr(jalr[0]), .i_auipc(auipc[0]), .i_lui(lui[0]), .i_trap(trap[0]),
        .i_iscomp(iscomp[0]), .i_offset(off[0][0:0]), .i_rs1(rs1[0][0:0]),
        .i_csr_pc(csr[0][0:0]), .o_rd(rd0), .o_bad_pc(bad0), .o_misalign(mis[0]),
        .o_ibus_adr(adr[0]), .o_ibus_cyc(cyc[0]), .i_ibus_ack(ack[0]));

    serv_ctrl_wide #(.W(4)) u_w4 (
        .clk(clk), .i_rst(rst), .i_en(en[1]), .i_pc_en(pc_en[1]), .i_jump(jump[1]),
        .i_jalr(jalr[1]), .i_auipc(auipc[1]), .i_lui(lui[1]), .i_trap(trap[1]),
        .i_iscomp(iscomp[1]), .i_offset(off[1][3:0]), .i_rs1(rs1[1][3:0]),
        .i_csr_pc(csr[1][3:0]), .o_rd(rd1), .o_bad_pc(bad1), .o_misalign(mis[1]),
        .o_ibus_adr(adr[1]), .o_ibus_cyc(cyc[1]), .i_ibus_ack(ack[1]));

    serv_ctrl_wide #(.W(2)) u_w2 (
        .clk(clk), .i_rst(rst), .i_en(en[2]), .i_pc_en(pc_en[2]), .i_jump(jump[2]),
        .i_jalr(jalr[2]), .i_auipc(auipc[2]), .i_lui(lui[2]), .i_trap(trap[2]),
        .i_iscomp(iscomp[2]), .i_offset(off[2][1:0]), .i_rs1(rs1[2][1:0]),
        .i_csr_pc(csr[2][1:0]), .o_rd(rd2), .o_bad_pc(bad2), .o_misalign(mis[2]),
        .o_ibus_adr(adr[2]), .o_ibus_cyc(cyc[2]), .i_ibus_ack(ack[2]));

    serv_ctrl_wide #(.W(2), .COMPRESSED(1'b1)) u_w2c (
        .clk(clk), .i_rst(rst), .i_en(en[3]), .i_pc_en(pc_en[3]), .i_jump(jump[3]),
        .i_jalr(jalr[3]), .i_auipc(auipc[3]), .i_lui(lui[3]), .i_trap(trap[3]),
        .i_iscomp(iscomp[3]), .i_offset(off[3][1:0]), .i_rs1(rs1[3][1:0]),
        .i_csr_pc(csr[3][1:0]), .o_rd(rd3), .o_bad_pc(bad3), .o_misalign(mis[3]),
        .o_ibus_adr(adr[3]), .o_ibus_cyc(cyc[3]), .i_ibus_ack(ack[3]));

    serv_ctrl_wide #(.W(8), .COMPRESSED(1'b1)) u_w8c (
        .clk(clk), .i_rst(rst), .i_en(en[4]), .i_pc_en(pc_en[4]), .i_jump(jump[4]),
        .i_jalr(jalr[4]), .i_auipc(auipc[4]), .i_lui(lui[4]), .i_trap(trap[4]),
        .i_iscomp(iscomp[4]), .i_offset(off[4]), .i_rs1(rs1[4]),
        .i_csr_pc(csr[4]), .o_rd(rd4), .o_bad_pc(bad4), .o_misalign(mis[4]),
        .o_ibus_adr(adr[4]), .o_ibus_cyc(cyc[4]), .i_ibus_ack(ack[4]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full serial update on instance i; returns the collected o_rd / o_bad_pc words.
    task automatic upd(input int i, input int w, input logic [31:0] o, input logic [31:0] r,
                       input logic [31:0] c, input logic j, input logic jl, input logic t,
                       input logic ic, input logic au, input logic lu, input logic e,
                       output logic [31:0] rdw, output logic [31:0] bdw);
        logic [8:0]  m9;
        logic [7:0]  m;
        logic [31:0] tmp;
        m9  = (9'd1 << w) - 9'd1;
        m   = m9[7:0];
        rdw = '0;
        bdw = '0;
        for (int k = 0; k < 32 / w; k++) begin
            @(negedge clk);
            pc_en[i] = 1'b1; en[i] = e; jump[i] = j; jalr[i] = jl; trap[i] = t;
            iscomp[i] = ic; auipc[i] = au; lui[i] = lu;
            tmp = o >> (k * w); off[i] = tmp[7:0] & m;
            tmp = r >> (k * w); rs1[i] = tmp[7:0] & m;
            tmp = c >> (k * w); csr[i] = tmp[7:0] & m;
            #1;
            rdw |= {24'd0, rd_all[i] & m} << (k * w);
            bdw |= {24'd0, bad_all[i] & m} << (k * w);
        end
        @(negedge clk);
        pc_en[i] = 1'b0; en[i] = 1'b0; jump[i] = 1'b0; jalr[i] = 1'b0; trap[i] = 1'b0;
        iscomp[i] = 1'b0; auipc[i] = 1'b0; lui[i] = 1'b0;
        off[i] = '0; rs1[i] = '0; csr[i] = '0;
    endtask

    // Called at the negedge right after an update: request rises, then ack drops it.
    task automatic fetch(input int i, input string tg);
        chk({tg, " cyc before"}, {31'd0, cyc[i]}, 32'd0);
        @(negedge clk);
        chk({tg, " cyc rise"}, {31'd0, cyc[i]}, 32'd1);
        ack[i] = 1'b1;
        @(negedge clk);
        ack[i] = 1'b0;
        chk({tg, " cyc fall"}, {31'd0, cyc[i]}, 32'd0);
    endtask

    logic [31:0] rdw, bdw;

    initial begin
        for (int i = 0; i < 5; i++) begin
            en[i] = 0; pc_en[i] = 0; jump[i] = 0; jalr[i] = 0; auipc[i] = 0; lui[i] = 0;
            trap[i] = 0; iscomp[i] = 0; ack[i] = 0; off[i] = 0; rs1[i] = 0; csr[i] = 0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst adr%0d", i), adr[i], 32'h8);
            chk($sformatf("rst cyc%0d", i), {31'd0, cyc[i]}, 32'd0);
            chk($sformatf("rst mis%0d", i), {31'd0, mis[i]}, 32'd0);
            ack[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ack[i] = 1'b0;
            chk($sformatf("stray ack cyc%0d", i), {31'd0, cyc[i]}, 32'd0);
        end

        // W=1 sequential step
        upd(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdw, bdw);
        chk("w1 seq adr", adr[0], 32'hC);
        chk("w1 seq rd", rdw, 32'hC);
        fetch(0, "w1");

        // W=4 jump to 0x100, then branch back by 8
        upd(1, 4, 32'hF8, 0, 0, 1, 0, 0, 0, 0, 0, 1, rdw, bdw);
        chk("w4 jmp adr", adr[1], 32'h100);
        fetch(1, "w4a");
        upd(1, 4, 32'hFFFF_FFF8, 0, 0, 1, 0, 0, 0, 0, 0, 1, rdw, bdw);
        chk("w4 br adr", adr[1], 32'hF8);
        chk("w4 br bad_pc", bdw, 32'hF8);
        chk("w4 br rd", rdw, 32'h104);
        chk("w4 br mis", {31'd0, mis[1]}, 32'd0);
        @(negedge clk);
        chk("w4 cyc pending", {31'd0, cyc[1]}, 32'd1);
        // New update without ack: request must be dropped as it starts
        upd(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdw, bdw);
        chk("w4 proto drop", {31'd0, cyc[1]}, 32'd0);
        chk("w4 seq adr", adr[1], 32'hFC);
        @(negedge clk);
        chk("w4 cyc again", {31'd0, cyc[1]}, 32'd1);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;

        // W=2 jalr to a misaligned target, with and without compressed support
        upd(2, 2, 0, 32'h1003, 0, 1, 1, 0, 0, 0, 0, 1, rdw, bdw);
        chk("w2 jalr adr", adr[2], 32'h1002);
        chk("w2 jalr bad_pc", bdw, 32'h1002);
        chk("w2 jalr mis", {31'd0, mis[2]}, 32'd1);
        fetch(2, "w2");
        upd(3, 2, 0, 32'h1003, 0, 1, 1, 0, 0, 0, 0, 1, rdw, bdw);
        chk("w2c jalr adr", adr[3], 32'h1002);
        chk("w2c jalr mis", {31'd0, mis[3]}, 32'd0);
        fetch(3, "w2c");
        upd(2, 2, 32'h3000, 0, 0, 0, 0, 0, 0, 1, 0, 1, rdw, bdw);
        chk("w2 auipc rd", rdw, 32'h4002);
        chk("w2 auipc adr", adr[2], 32'h1006);
        fetch(2, "w2b");
        upd(3, 2, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 1, 0, rdw, bdw);
        chk("w2c lui rd", rdw, 32'h1234_5678);
        chk("w2c lui adr", adr[3], 32'h1006);
        fetch(3, "w2cb");

        // W=8 traps and compressed stepping
        upd(4, 8, 0, 0, 32'h2000_0003, 0, 0, 1, 0, 0, 0, 0, rdw, bdw);
        chk("w8 trap adr", adr[4], 32'h2000_0000);
        fetch(4, "w8");
        upd(4, 8, 0, 0, 32'h10, 0, 0, 1, 0, 0, 0, 0, rdw, bdw);
        chk("w8 trap2 adr", adr[4], 32'h10);
        fetch(4, "w8b");
        upd(4, 8, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, rdw, bdw);
        chk("w8 comp adr", adr[4], 32'h12);
        chk("w8 comp rd", rdw, 32'h12);
        fetch(4, "w8c");
        upd(4, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdw, bdw);
        chk("w8 seq adr", adr[4], 32'h16);
        fetch(4, "w8d");

        // Reset in the middle of a W=1 update
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pc_en[0] = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pc_en[0] = 1'b0;
        chk("midrst adr", adr[0], 32'h8);
        chk("midrst cyc", {31'd0, cyc[0]}, 32'd0);
        @(negedge clk);
        chk("midrst idle cyc", {31'd0, cyc[0]}, 32'd0);
        upd(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdw, bdw);
        chk("postrst adr", adr[0], 32'hC);
        chk("postrst rd", rdw, 32'hC);
        fetch(0, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
